update_mask_multi: RTL and testbench
====================================

Name: update_mask_multi

Overview:
- Parametrised successor to the single-bit attention-mask updater in the sparsity path.
- Takes a binary input mask and the compacted output vector produced for the set mask positions, and prunes positions whose output magnitude is at or below a programmable threshold.
- Processes LANES mask bits per cycle. Reports the non-zero count and an overflow flag.
- Sits between the softmax/activation stage and the next layer's sparse scheduler.

Parameters:
- IL, 4, integer bits of the fixed-point output values.
- FL, 16, fractional bits; W = IL+FL.
- LENGTH, 32, mask width in bits.
- N_OUT, 16, number of entries in the out vector.
- LANES, 4, mask bits processed per RUN cycle; must divide LENGTH, 1..LENGTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_mask  in  LENGTH  input mask.
- out  in  N_OUT x W signed  compacted values; entry k belongs to the k-th set bit of i_mask, counted from bit 0.
- threshold  in  W unsigned  prune threshold on magnitude.
- input_ready  in  1  request to accept new operands.
- output_taken  in  1  consumer has taken the result.
- o_mask  out  LENGTH  updated mask (registered).
- o_nnz  out  $clog2(LENGTH+1)  number of ones in o_mask.
- overflow  out  1  i_mask had more than N_OUT set bits.
- state  out  2  00 IDLE, 01 RUN, 10 DONE.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; o_mask, o_nnz, overflow=0; all internal registers and pointers zero.
  - Reset asserted mid-RUN or in DONE aborts immediately and discards the result.
- IDLE:
  - On input_ready=1, latch i_mask, out and threshold.
  - Clear group pointer g, out pointer p, o_mask, o_nnz and overflow.
  - Next state is RUN.
- RUN, one group per cycle:
  - Group g covers bits g*LANES .. g*LANES+LANES-1.
  - For each bit b in ascending order, let k = p + (number of set i_mask bits below b within the group).
  - If i_mask[b]=0: o_mask[b]=0.
  - Else if k >= N_OUT: o_mask[b]=0 and overflow sets (sticky).
  - Else: o_mask[b] = (|out[k]| > threshold), strict comparison.
- Magnitude arithmetic:
  - |x| is computed in W+1 bits, so -2^(W-1) has magnitude 2^(W-1) with no wrap.
  - Threshold is zero-extended to W+1 bits.
- Pointer updates:
  - p advances by the popcount of the group's i_mask bits; p saturates at N_OUT.
  - o_nnz accumulates the kept bits.
  - g increments each cycle.
- Leaving RUN: after group LENGTH/LANES-1 is processed, next state is DONE.
- Latency: the accept edge is at cycle 0; o_mask, o_nnz and overflow are final and state=DONE after LENGTH/LANES+1 edges.
- DONE:
  - Outputs hold stable.
  - On output_taken=1: next state is IDLE, and o_mask, o_nnz and overflow clear at the same edge.
- Handshakes:
  - input_ready is ignored outside IDLE.
  - output_taken is ignored outside DONE.
  - If input_ready and output_taken are both high in DONE, go to IDLE only; the input is accepted no earlier than the next cycle.
- State encoding 11 is illegal and returns to IDLE on the next edge, with outputs cleared.
- i_mask=0: RUN still takes LENGTH/LANES cycles; result o_mask=0, o_nnz=0, overflow=0.

Optional Feature:
- Macro: UPDATE_MASK_MULTI_STATS_EN.
- When defined:
  - Adds output o_pruned (width $clog2(LENGTH+1)): count of bits set in i_mask but cleared in o_mask, including overflow-cleared bits.
  - Valid in DONE; cleared on reset, on accept and on output_taken.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Basic prune (LENGTH=32, LANES=4, N_OUT=16, threshold=0):
  - Stimulus: i_mask=0x0000FFFF, out all 5 except out[3]=0.
  - Response: exactly 8 RUN cycles, then DONE with o_mask=0x0000FFF7, o_nnz=15, overflow=0.
- Threshold with signed values:
  - Stimulus: i_mask=0xAAAAAAAA, out[k]=k-8, threshold=2.
  - Response: o_mask=0xAA800AAA, o_nnz=11.
- Overflow:
  - Stimulus: i_mask=0xFFFFFFFF, out all 1, threshold=0.
  - Response: o_mask=0x0000FFFF, o_nnz=16, overflow=1; with STATS_EN, o_pruned=16.
- Magnitude edge:
  - Stimulus: i_mask=0x1, out[0]=0x80000 (-2^19), threshold=0x7FFFF.
  - Response: o_mask=0x1.
  - Repeat with out[0]=0x7FFFF: o_mask=0x0 (strict compare).
- Control:
  - input_ready pulsed during RUN: ignored, result unchanged.
  - Reset asserted at RUN cycle 3: state=00, o_mask=0 the next cycle.
  - output_taken and input_ready together in DONE: IDLE for one cycle, then accept.
- LANES=1 and LANES=32 builds with scenario 2 stimulus: identical o_mask; 32 and 1 RUN cycles respectively.

Source files
------------

// File: rtl/update_mask_multi_if.sv
// Operand/result bundle for update_mask_multi.
// UPDATE_MASK_MULTI_STATS_EN adds the o_pruned result field.
interface update_mask_multi_if #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int LENGTH = 32,
  parameter int N_OUT  = 16
);
  localparam int W  = IL + FL;
  localparam int CW = $clog2(LENGTH + 1);

  logic [LENGTH-1:0]           i_mask;
  logic [N_OUT-1:0][W-1:0]     out;
  logic [W-1:0]                threshold;
  logic                        input_ready;
  logic                        output_taken;
  logic [LENGTH-1:0]           o_mask;
  logic [CW-1:0]               o_nnz;
  logic                        overflow;
  logic [1:0]                  state;
  logic                        busy;
`ifdef UPDATE_MASK_MULTI_STATS_EN
  logic [CW-1:0]               o_pruned;

  modport master (
    output i_mask, out, threshold, input_ready, output_taken,
    input  o_mask, o_nnz, overflow, state, busy, o_pruned
  );
  modport slave (
    input  i_mask, out, threshold, input_ready, output_taken,
    output o_mask, o_nnz, overflow, state, busy, o_pruned
  );
`else
  modport master (
    output i_mask, out, threshold, input_ready, output_taken,
    input  o_mask, o_nnz, overflow, state, busy
  );
  modport slave (
    input  i_mask, out, threshold, input_ready, output_taken,
    output o_mask, o_nnz, overflow, state, busy
  );
`endif
endinterface

// File: rtl/update_mask_multi.sv
// Prunes mask bits whose compacted value magnitude is <= threshold, LANES bits per cycle.
// UPDATE_MASK_MULTI_STATS_EN adds the o_pruned counter.
// state | meaning
// 00    | IDLE: wait for input_ready, latch operands
// 01    | RUN : one LANES-wide group per cycle
// 10    | DONE: hold result until output_taken
// 11    | illegal, recovers to IDLE with outputs cleared
module update_mask_multi #(
  parameter int IL     = 4,
  parameter int FL     = 16,
  parameter int LENGTH = 32,
  parameter int N_OUT  = 16,
  parameter int LANES  = 4
) (
  input logic               clk,
  input logic               reset,
  update_mask_multi_if.slave bus
);
  localparam int W  = IL + FL;
  localparam int W1 = W + 1;
  localparam int NG = LENGTH / LANES;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW = $clog2(N_OUT + 1);
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int CW = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           g_q, g_d;
  logic [PW-1:0]           p_q, p_d;
  logic [LENGTH-1:0]       mask_q, mask_d;
  logic [N_OUT-1:0][W-1:0] out_q, out_d;
  logic [W-1:0]            thr_q, thr_d;
  logic [LENGTH-1:0]       o_mask_q, o_mask_d;
  logic [CW-1:0]           nnz_q, nnz_d;
  logic                    ovf_q, ovf_d;
`ifdef UPDATE_MASK_MULTI_STATS_EN
  logic [CW-1:0]           pruned_q, pruned_d;
`endif

  logic [LANES-1:0]        grp_mask;
  logic [LANES-1:0]        keep;
  logic signed [W:0]       val_ext;
  logic [W:0]              mag;
  int                      cnt;
  int                      k;

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    p_d      = p_q;
    mask_d   = mask_q;
    out_d    = out_q;
    thr_d    = thr_q;
    o_mask_d = o_mask_q;
    nnz_d    = nnz_q;
    ovf_d    = ovf_q;
`ifdef UPDATE_MASK_MULTI_STATS_EN
    pruned_d = pruned_q;
`endif
    grp_mask = '0;
    keep     = '0;
    val_ext  = '0;
    mag      = '0;
    cnt      = 0;
    k        = 0;

    case (state_q)
      S_IDLE: begin
        if (bus.input_ready) begin
          mask_d   = bus.i_mask;
          out_d    = bus.out;
          thr_d    = bus.threshold;
          g_d      = '0;
          p_d      = '0;
          o_mask_d = '0;
          nnz_d    = '0;
          ovf_d    = 1'b0;
`ifdef UPDATE_MASK_MULTI_STATS_EN
          pruned_d = '0;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        grp_mask = LANES'(mask_q >> (int'(g_q) * LANES));
        for (int l = 0; l < LANES; l++) begin
          if (grp_mask[l]) begin
            k = int'(p_q) + cnt;
            if (k >= N_OUT) begin
              ovf_d = 1'b1;
            end else begin
              // one extra bit so the most negative value keeps its true magnitude
              val_ext = W1'($signed(out_q[KW'(k)]));
              mag     = val_ext[W] ? -val_ext : val_ext;
              keep[l] = (mag > {1'b0, thr_q});
            end
            cnt = cnt + 1;
          end
        end
        o_mask_d = o_mask_q | (LENGTH'(keep) << (int'(g_q) * LANES));
        nnz_d    = nnz_q + CW'($countones(keep));
`ifdef UPDATE_MASK_MULTI_STATS_EN
        pruned_d = pruned_q + CW'(cnt - $countones(keep));
`endif
        p_d      = (int'(p_q) + cnt >= N_OUT) ? PW'(N_OUT) : PW'(int'(p_q) + cnt);
        g_d      = g_q + 1'b1;
        if (g_q == GW'(NG - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.output_taken) begin
          o_mask_d = '0;
          nnz_d    = '0;
          ovf_d    = 1'b0;
`ifdef UPDATE_MASK_MULTI_STATS_EN
          pruned_d = '0;
`endif
          state_d  = S_IDLE;
        end
      end
      default: begin
        o_mask_d = '0;
        nnz_d    = '0;
        ovf_d    = 1'b0;
`ifdef UPDATE_MASK_MULTI_STATS_EN
        pruned_d = '0;
`endif
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      p_q      <= '0;
      mask_q   <= '0;
      out_q    <= '0;
      thr_q    <= '0;
      o_mask_q <= '0;
      nnz_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef UPDATE_MASK_MULTI_STATS_EN
      pruned_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      p_q      <= p_d;
      mask_q   <= mask_d;
      out_q    <= out_d;
      thr_q    <= thr_d;
      o_mask_q <= o_mask_d;
      nnz_q    <= nnz_d;
      ovf_q    <= ovf_d;
`ifdef UPDATE_MASK_MULTI_STATS_EN
      pruned_q <= pruned_d;
`endif
    end
  end

  assign bus.o_mask   = o_mask_q;
  assign bus.o_nnz    = nnz_q;
  assign bus.overflow = ovf_q;
  assign bus.state    = state_q;
  assign bus.busy     = (state_q != S_IDLE);
`ifdef UPDATE_MASK_MULTI_STATS_EN
  assign bus.o_pruned = pruned_q;
`endif
endmodule

// File: tb/tb_update_mask_multi.sv
// Self-checking bench for update_mask_multi: directed vector table, hand-written
// control sequences, LANES=1/32 variants and random operands against a reference model.
`timescale 1ns/1ps
module tb_update_mask_multi;
  localparam int IL = 4, FL = 16, W = IL + FL, LENGTH = 32, N_OUT = 16;

  typedef logic [N_OUT-1:0][W-1:0] outvec_t;
  typedef struct {
    logic [31:0]  mask;
    outvec_t      outv;
    logic [W-1:0] thr;
    logic [31:0]  exp_mask;
    int           exp_nnz;
    bit           exp_ovf;
    int           exp_pruned;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  update_mask_multi_if #(.IL(IL), .FL(FL), .LENGTH(LENGTH), .N_OUT(N_OUT)) ifc ();
  update_mask_multi_if #(.IL(IL), .FL(FL), .LENGTH(LENGTH), .N_OUT(N_OUT)) ifc1 ();
  update_mask_multi_if #(.IL(IL), .FL(FL), .LENGTH(LENGTH), .N_OUT(N_OUT)) ifc32 ();

  update_mask_multi #(.IL(IL), .FL(FL), .LENGTH(LENGTH), .N_OUT(N_OUT), .LANES(4))
    dut (.clk(clk), .reset(reset), .bus(ifc));
  update_mask_multi #(.IL(IL), .FL(FL), .LENGTH(LENGTH), .N_OUT(N_OUT), .LANES(1))
    dut_l1 (.clk(clk), .reset(reset), .bus(ifc1));
  update_mask_multi #(.IL(IL), .FL(FL), .LENGTH(LENGTH), .N_OUT(N_OUT), .LANES(32))
    dut_l32 (.clk(clk), .reset(reset), .bus(ifc32));

  assign ifc1.i_mask        = ifc.i_mask;
  assign ifc1.out           = ifc.out;
  assign ifc1.threshold     = ifc.threshold;
  assign ifc1.input_ready   = ifc.input_ready;
  assign ifc1.output_taken  = ifc.output_taken;
  assign ifc32.i_mask       = ifc.i_mask;
  assign ifc32.out          = ifc.out;
  assign ifc32.threshold    = ifc.threshold;
  assign ifc32.input_ready  = ifc.input_ready;
  assign ifc32.output_taken = ifc.output_taken;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Walk the set mask bits in order; the k-th set bit owns out[k].
  function automatic void model(input logic [31:0] m, input outvec_t o, input logic [W-1:0] t,
                                output logic [31:0] om, output int nnz, output bit ovf,
                                output int pruned);
    int kk;
    longint v;
    om = '0; nnz = 0; ovf = 1'b0; pruned = 0; kk = 0;
    for (int b = 0; b < LENGTH; b++) begin
      if (m[b]) begin
        if (kk >= N_OUT) begin
          ovf = 1'b1;
          pruned++;
        end else begin
          v = longint'($signed(o[kk]));
          if (v < 0) v = -v;
          if (v > longint'(t)) begin
            om[b] = 1'b1;
            nnz++;
          end else begin
            pruned++;
          end
        end
        kk++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_bus(input logic [31:0] m, input outvec_t o, input logic [W-1:0] t);
    ifc.i_mask    = m;
    ifc.out       = o;
    ifc.threshold = t;
  endtask

  task automatic accept();
    ifc.input_ready = 1'b1;
    tick();
    ifc.input_ready = 1'b0;
  endtask

  task automatic take();
    ifc.output_taken = 1'b1;
    tick();
    ifc.output_taken = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (ifc.state != 2'b10 && n < 100) begin
      tick();
      n++;
    end
    if (ifc.state != 2'b10) chk({nm, "_timeout"}, ifc.state, 2'b10);
  endtask

  task automatic run_check(input string nm, input logic [31:0] m, input outvec_t o,
                           input logic [W-1:0] t, input logic [31:0] em, input int en,
                           input bit eo, input int ep);
    int n;
    apply_bus(m, o, t);
    accept();
    chk({nm, "_busy"}, ifc.busy, 1'b1);
    wait_done(nm, n);
    chk({nm, "_cycles"}, n, 8);
    chk({nm, "_mask"}, ifc.o_mask, em);
    chk({nm, "_nnz"}, ifc.o_nnz, en);
    chk({nm, "_ovf"}, ifc.overflow, eo);
`ifdef UPDATE_MASK_MULTI_STATS_EN
    chk({nm, "_pruned"}, ifc.o_pruned, ep);
`else
    if (ep < 0) chk({nm, "_pruned_neg"}, ep, 0);
`endif
    repeat (2) tick();
    chk({nm, "_hold"}, ifc.o_mask, em);
    take();
    chk({nm, "_idle"}, ifc.state, 2'b00);
    chk({nm, "_clr_mask"}, ifc.o_mask, 0);
    chk({nm, "_clr_nnz"}, ifc.o_nnz, 0);
    chk({nm, "_clr_ovf"}, ifc.overflow, 0);
  endtask

  vec_t vecs[6];

  initial begin
    outvec_t o;
    logic [31:0] m, em;
    int en, ep, n, n4, n1, n32;
    bit eo, d4, d1, d32;

    // directed table
    for (int k = 0; k < N_OUT; k++) o[k] = W'(5);
    o[3] = '0;
    vecs[0] = '{32'h0000FFFF, o, W'(0), 32'h0000FFF7, 15, 1'b0, 1};
    for (int k = 0; k < N_OUT; k++) o[k] = W'(k - 8);
    vecs[1] = '{32'hAAAAAAAA, o, W'(2), 32'hAA800AAA, 11, 1'b0, 5};
    for (int k = 0; k < N_OUT; k++) o[k] = W'(1);
    vecs[2] = '{32'hFFFFFFFF, o, W'(0), 32'h0000FFFF, 16, 1'b1, 16};
    o = '0;
    o[0] = W'(20'h80000);
    vecs[3] = '{32'h00000001, o, W'(20'h7FFFF), 32'h00000001, 1, 1'b0, 0};
    o[0] = W'(20'h7FFFF);
    vecs[4] = '{32'h00000001, o, W'(20'h7FFFF), 32'h00000000, 0, 1'b0, 1};
    for (int k = 0; k < N_OUT; k++) o[k] = W'(k + 100);
    vecs[5] = '{32'h00000000, o, W'(0), 32'h00000000, 0, 1'b0, 0};

    reset = 1'b1;
    ifc.input_ready = 1'b0;
    ifc.output_taken = 1'b0;
    apply_bus('0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_state", ifc.state, 2'b00);
    chk("rst_mask", ifc.o_mask, 0);
    chk("rst_nnz", ifc.o_nnz, 0);
    chk("rst_ovf", ifc.overflow, 0);
    chk("rst_busy", ifc.busy, 0);
    tick();
    chk("idle_stays", ifc.state, 2'b00);

    for (int i = 0; i < 6; i++)
      run_check($sformatf("vec%0d", i), vecs[i].mask, vecs[i].outv, vecs[i].thr,
                vecs[i].exp_mask, vecs[i].exp_nnz, vecs[i].exp_ovf, vecs[i].exp_pruned);

    // input_ready pulsed mid-RUN with different operands on the bus
    apply_bus(vecs[1].mask, vecs[1].outv, vecs[1].thr);
    accept();
    repeat (2) tick();
    apply_bus(32'hFFFFFFFF, '0, '0);
    ifc.input_ready = 1'b1;
    tick();
    ifc.input_ready = 1'b0;
    chk("ir_run_state", ifc.state, 2'b01);
    wait_done("ir_run", n);
    chk("ir_run_cycles", n, 5);
    chk("ir_run_mask", ifc.o_mask, 32'hAA800AAA);
    chk("ir_run_nnz", ifc.o_nnz, 11);
    take();

    // reset at RUN cycle 3
    apply_bus(vecs[2].mask, vecs[2].outv, vecs[2].thr);
    accept();
    repeat (3) tick();
    chk("midrst_partial", ifc.o_mask, 32'h00000FFF);
    reset = 1'b1;
    tick();
    chk("midrst_state", ifc.state, 2'b00);
    chk("midrst_mask", ifc.o_mask, 0);
    chk("midrst_nnz", ifc.o_nnz, 0);
    chk("midrst_busy", ifc.busy, 0);
    reset = 1'b0;
    tick();
    chk("midrst_idle", ifc.state, 2'b00);

    // output_taken and input_ready together in DONE
    apply_bus(vecs[0].mask, vecs[0].outv, vecs[0].thr);
    accept();
    wait_done("both", n);
    chk("both_first", ifc.o_mask, 32'h0000FFF7);
    apply_bus(vecs[1].mask, vecs[1].outv, vecs[1].thr);
    ifc.input_ready = 1'b1;
    ifc.output_taken = 1'b1;
    tick();
    ifc.output_taken = 1'b0;
    chk("both_idle", ifc.state, 2'b00);
    chk("both_clr", ifc.o_mask, 0);
    tick();
    ifc.input_ready = 1'b0;
    chk("both_accept", ifc.state, 2'b01);
    wait_done("both2", n);
    chk("both2_cycles", n, 8);
    chk("both2_mask", ifc.o_mask, 32'hAA800AAA);
    take();

    // LANES=4 / 1 / 32 side by side
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    apply_bus(vecs[1].mask, vecs[1].outv, vecs[1].thr);
    accept();
    n = 0; n4 = -1; n1 = -1; n32 = -1; d4 = 0; d1 = 0; d32 = 0;
    while (!(d4 && d1 && d32) && n < 60) begin
      tick();
      n++;
      if (!d4 && ifc.state == 2'b10) begin d4 = 1; n4 = n; end
      if (!d1 && ifc1.state == 2'b10) begin d1 = 1; n1 = n; end
      if (!d32 && ifc32.state == 2'b10) begin d32 = 1; n32 = n; end
    end
    chk("lanes4_cycles", n4, 8);
    chk("lanes1_cycles", n1, 32);
    chk("lanes32_cycles", n32, 1);
    chk("lanes4_mask", ifc.o_mask, 32'hAA800AAA);
    chk("lanes1_mask", ifc1.o_mask, 32'hAA800AAA);
    chk("lanes32_mask", ifc32.o_mask, 32'hAA800AAA);
    chk("lanes1_nnz", ifc1.o_nnz, 11);
    chk("lanes32_nnz", ifc32.o_nnz, 11);
    take();
    chk("lanes1_idle", ifc1.state, 2'b00);
    chk("lanes32_idle", ifc32.state, 2'b00);

    // random operands against the model
    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] t;
      m = $urandom;
      if (i % 4 == 1) m = m & $urandom & $urandom;
      if (i % 7 == 3) m = m | $urandom;
      for (int k = 0; k < N_OUT; k++)
        o[k] = (i % 3 == 0) ? W'($urandom) : W'(int'($urandom_range(0, 8192)) - 4096);
      t = (i % 5 == 0) ? W'($urandom) : W'($urandom_range(0, 4096));
      if (i % 6 == 2) t = o[0][W-1] ? W'(-$signed(o[0])) : o[0];
      model(m, o, t, em, en, eo, ep);
      run_check($sformatf("rand%0d", i), m, o, t, em, en, eo, ep);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
